// File: rtl/modn_up_counter.sv
// Modulo-N up counter with sync clear, parallel load, cascade terminal count,
// one-cycle wrap pulse, saturating wrap tally with sticky overflow and a
// load-range error pulse. Reset is asynchronous and active-low.
module modn_up_counter #(
    parameter  int MODULUS = 4,
    parameter  int WRAP_W  = 8,
    localparam int WIDTH   = $clog2(MODULUS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              wrap_ovf,
    output logic              load_err
);

    // Last legal count value; the wrap step happens from here.
    localparam logic [WIDTH-1:0]  LAST_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS itself is representable for the range check
    // (MODULUS == 2**WIDTH when it is a power of two).
    localparam logic [WIDTH:0]    MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic [WIDTH-1:0]  count_reg,    count_next;
    logic              wrap_reg,     wrap_next;
    logic [WRAP_W-1:0] wrap_cnt_reg, wrap_cnt_next;
    logic              wrap_ovf_reg, wrap_ovf_next;
    logic              load_err_reg, load_err_next;

    logic at_last;
    logic load_ok;

    assign at_last = (count_reg == LAST_VAL);
    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    // Next-state logic: clr > load > en > hold; pulses default low each cycle.
    always_comb begin
        count_next    = count_reg;
        wrap_next     = 1'b0;
        wrap_cnt_next = wrap_cnt_reg;
        wrap_ovf_next = wrap_ovf_reg;
        load_err_next = 1'b0;

        if (clr) begin
            count_next    = '0;
            wrap_cnt_next = '0;
            wrap_ovf_next = 1'b0;
        end else if (load) begin
            // An out-of-range value is rejected so count never leaves 0..MODULUS-1.
            if (load_ok) begin
                count_next = load_val;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (en) begin
            if (at_last) begin
                count_next = '0;
                wrap_next  = 1'b1;
                // Tally saturates; a wrap beyond saturation is recorded as overflow.
                if (wrap_cnt_reg == WRAP_MAX) begin
                    wrap_ovf_next = 1'b1;
                end else begin
                    wrap_cnt_next = wrap_cnt_reg + 1'b1;
                end
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg    <= '0;
            wrap_reg     <= 1'b0;
            wrap_cnt_reg <= '0;
            wrap_ovf_reg <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            wrap_reg     <= wrap_next;
            wrap_cnt_reg <= wrap_cnt_next;
            wrap_ovf_reg <= wrap_ovf_next;
            load_err_reg <= load_err_next;
        end
    end

    // Terminal count is combinational so a cascaded stage steps on this wrap edge.
    assign tc       = en && at_last;
    assign count    = count_reg;
    assign wrap     = wrap_reg;
    assign wrap_cnt = wrap_cnt_reg;
    assign wrap_ovf = wrap_ovf_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_modn_up_counter.sv
// Self-checking bench for modn_up_counter: table-driven vectors for MODULUS=4
// and MODULUS=5, plus hand sequences for tally saturation, cascading and
// asynchronous reset.
module tb_modn_up_counter;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MODULUS=4, WRAP_W=8
    logic en4, clr4, load4, tc4, wrap4, ovf4, lerr4;
    logic [1:0] lv4, count4;
    logic [7:0] wc4;
    // MODULUS=5, WRAP_W=8
    logic en5, clr5, load5, tc5, wrap5, ovf5, lerr5;
    logic [2:0] lv5, count5;
    logic [7:0] wc5;
    // MODULUS=4, WRAP_W=2
    logic enw, clrw, loadw, tcw, wrapw, ovfw, lerrw;
    logic [1:0] lvw, countw, wcw;
    // Cascaded pair, MODULUS=4
    logic enl, tcl, wrapl, ovfl, lerrl, tch, wraph, ovfh, lerrh;
    logic [1:0] countl, counth;
    logic [7:0] wcl, wch;
    logic [1:0] zero2;

    modn_up_counter #(.MODULUS(4), .WRAP_W(8)) u4 (
        .clk(clk), .reset(reset), .en(en4), .clr(clr4), .load(load4), .load_val(lv4),
        .count(count4), .tc(tc4), .wrap(wrap4), .wrap_cnt(wc4), .wrap_ovf(ovf4), .load_err(lerr4));

    modn_up_counter #(.MODULUS(5), .WRAP_W(8)) u5 (
        .clk(clk), .reset(reset), .en(en5), .clr(clr5), .load(load5), .load_val(lv5),
        .count(count5), .tc(tc5), .wrap(wrap5), .wrap_cnt(wc5), .wrap_ovf(ovf5), .load_err(lerr5));

    modn_up_counter #(.MODULUS(4), .WRAP_W(2)) uw (
        .clk(clk), .reset(reset), .en(enw), .clr(clrw), .load(loadw), .load_val(lvw),
        .count(countw), .tc(tcw), .wrap(wrapw), .wrap_cnt(wcw), .wrap_ovf(ovfw), .load_err(lerrw));

    modn_up_counter #(.MODULUS(4), .WRAP_W(8)) ulo (
        .clk(clk), .reset(reset), .en(enl), .clr(1'b0), .load(1'b0), .load_val(zero2),
        .count(countl), .tc(tcl), .wrap(wrapl), .wrap_cnt(wcl), .wrap_ovf(ovfl), .load_err(lerrl));

    modn_up_counter #(.MODULUS(4), .WRAP_W(8)) uhi (
        .clk(clk), .reset(reset), .en(tcl), .clr(1'b0), .load(1'b0), .load_val(zero2),
        .count(counth), .tc(tch), .wrap(wraph), .wrap_cnt(wch), .wrap_ovf(ovfh), .load_err(lerrh));

    typedef struct {
        logic       clr;
        logic       load;
        logic       en;
        logic [2:0] lv;
        logic       tc;     // expected before the edge
        logic [2:0] cnt;    // expected after the edge
        logic       wrap;
        logic [7:0] wc;
        logic       lerr;
    } vec_t;

    vec_t v4[12];
    vec_t v5[17];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input int i);
        clr4 = v4[i].clr; load4 = v4[i].load; en4 = v4[i].en; lv4 = v4[i].lv[1:0];
        #1;
        chk($sformatf("m4[%0d].tc", i), {31'd0, tc4}, {31'd0, v4[i].tc});
        tick();
        chk($sformatf("m4[%0d].count", i), {30'd0, count4}, {29'd0, v4[i].cnt});
        chk($sformatf("m4[%0d].wrap", i), {31'd0, wrap4}, {31'd0, v4[i].wrap});
        chk($sformatf("m4[%0d].wrap_cnt", i), {24'd0, wc4}, {24'd0, v4[i].wc});
        chk($sformatf("m4[%0d].load_err", i), {31'd0, lerr4}, {31'd0, v4[i].lerr});
        $display("m4 vec %0d: clr=%0b load=%0b val=%0d en=%0b -> count=%0d wrap=%0b wrap_cnt=%0d load_err=%0b",
                 i, clr4, load4, lv4, en4, count4, wrap4, wc4, lerr4);
    endtask

    task automatic run5(input int i);
        clr5 = v5[i].clr; load5 = v5[i].load; en5 = v5[i].en; lv5 = v5[i].lv;
        #1;
        chk($sformatf("m5[%0d].tc", i), {31'd0, tc5}, {31'd0, v5[i].tc});
        tick();
        chk($sformatf("m5[%0d].count", i), {29'd0, count5}, {29'd0, v5[i].cnt});
        chk($sformatf("m5[%0d].wrap", i), {31'd0, wrap5}, {31'd0, v5[i].wrap});
        chk($sformatf("m5[%0d].wrap_cnt", i), {24'd0, wc5}, {24'd0, v5[i].wc});
        chk($sformatf("m5[%0d].load_err", i), {31'd0, lerr5}, {31'd0, v5[i].lerr});
        $display("m5 vec %0d: clr=%0b load=%0b val=%0d en=%0b -> count=%0d wrap=%0b wrap_cnt=%0d load_err=%0b",
                 i, clr5, load5, lv5, en5, count5, wrap5, wc5, lerr5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vectors for MODULUS=4: {clr, load, en, load_val, tc, count, wrap, wrap_cnt, load_err}
        v4[0]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 8'd0, 1'b0};
        v4[1]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd2, 1'b0, 8'd0, 1'b0};
        v4[2]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 8'd0, 1'b0};
        v4[3]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 8'd1, 1'b0};
        v4[4]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 8'd1, 1'b0};
        v4[5]  = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0}; // clr beats load and en
        v4[6]  = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 3'd3, 1'b0, 8'd0, 1'b0}; // load MODULUS-1
        v4[7]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 8'd0, 1'b0}; // tc low while en low
        v4[8]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 8'd1, 1'b0};
        v4[9]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'd1, 1'b0};
        v4[10] = '{1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 3'd1, 1'b0, 8'd1, 1'b0}; // load beats en
        v4[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0};

        // Vectors for MODULUS=5
        v5[0]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 8'd0, 1'b0};
        v5[1]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd2, 1'b0, 8'd0, 1'b0};
        v5[2]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 8'd0, 1'b0};
        v5[3]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 8'd0, 1'b0};
        v5[4]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 8'd1, 1'b0};
        v5[5]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 8'd1, 1'b0};
        v5[6]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd2, 1'b0, 8'd1, 1'b0};
        v5[7]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 8'd1, 1'b0};
        v5[8]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 8'd1, 1'b0};
        v5[9]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 8'd2, 1'b0};
        v5[10] = '{1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 3'd0, 1'b0, 8'd2, 1'b1}; // out-of-range load
        v5[11] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'd2, 1'b0}; // pulse lasts one cycle
        v5[12] = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 8'd2, 1'b1}; // load_val == MODULUS
        v5[13] = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4, 1'b0, 8'd2, 1'b0};
        v5[14] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 8'd3, 1'b0};
        v5[15] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'd3, 1'b0};
        v5[16] = '{1'b1, 1'b1, 1'b0, 3'd7, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0}; // clr suppresses load_err

        reset = 1'b0;
        zero2 = 2'd0;
        en4 = 0; clr4 = 0; load4 = 0; lv4 = 0;
        en5 = 0; clr5 = 0; load5 = 0; lv5 = 0;
        enw = 0; clrw = 0; loadw = 0; lvw = 0;
        enl = 0;

        // Reset held low for two cycles
        tick();
        tick();
        chk("reset.count", {30'd0, count4}, 32'd0);
        chk("reset.wrap", {31'd0, wrap4}, 32'd0);
        chk("reset.wrap_cnt", {24'd0, wc4}, 32'd0);
        chk("reset.wrap_ovf", {31'd0, ovf4}, 32'd0);
        chk("reset.load_err", {31'd0, lerr4}, 32'd0);
        chk("reset.tc", {31'd0, tc4}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) run4(i);
        en4 = 0; clr4 = 0; load4 = 0;
        for (int i = 0; i < 17; i++) run5(i);
        en5 = 0; clr5 = 0; load5 = 0;

        // Tally saturation with a 2-bit wrap counter
        enw = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            $display("wsat edge %0d: count=%0d wrap=%0b wrap_cnt=%0d wrap_ovf=%0b", k, countw, wrapw, wcw, ovfw);
            if (k % 4 == 0) begin
                chk($sformatf("wsat[%0d].wrap", k), {31'd0, wrapw}, 32'd1);
                chk($sformatf("wsat[%0d].wrap_cnt", k), {30'd0, wcw}, (k / 4 > 3) ? 32'd3 : 32'(k / 4));
                chk($sformatf("wsat[%0d].wrap_ovf", k), {31'd0, ovfw}, (k / 4 >= 4) ? 32'd1 : 32'd0);
            end
        end
        enw = 1'b0;
        clrw = 1'b1;
        tick();
        clrw = 1'b0;
        $display("wsat clr: wrap_cnt=%0d wrap_ovf=%0b", wcw, ovfw);
        chk("wsat.clr.wrap_cnt", {30'd0, wcw}, 32'd0);
        chk("wsat.clr.wrap_ovf", {31'd0, ovfw}, 32'd0);

        // Cascade: upper stage advances once per four lower edges
        enl = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            $display("chain edge %0d: lo=%0d hi=%0d", k, countl, counth);
            chk($sformatf("chain[%0d].lo", k), {30'd0, countl}, 32'(k % 4));
            if (k % 4 == 0)
                chk($sformatf("chain[%0d].hi", k), {30'd0, counth}, 32'((k / 4) % 4));
        end
        chk("chain.lo.wrap", {31'd0, wrapl}, 32'd1);
        chk("chain.lo.wrap_cnt", {24'd0, wcl}, 32'd4);

        // Reset during the wrap pulse clears everything without a clock edge
        #2;
        reset = 1'b0;
        #1;
        $display("reset mid-pulse: lo=%0d wrap=%0b wrap_cnt=%0d hi_wrap_cnt=%0d", countl, wrapl, wcl, wch);
        chk("rst_pulse.wrap", {31'd0, wrapl}, 32'd0);
        chk("rst_pulse.wrap_cnt", {24'd0, wcl}, 32'd0);
        chk("rst_pulse.hi_wrap_cnt", {24'd0, wch}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("rst_pulse.first_edge", {30'd0, countl}, 32'd1);
        tick();
        chk("mid.count2", {30'd0, countl}, 32'd2);

        // Reset mid-count between edges
        #2;
        reset = 1'b0;
        #1;
        $display("reset mid-count: lo=%0d", countl);
        chk("rst_mid.count", {30'd0, countl}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        $display("after release: lo=%0d", countl);
        chk("rst_mid.first_edge", {30'd0, countl}, 32'd1);
        enl = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
